// File: rtl/instr_encoder_pkg.sv
// Shared RV32I encode/decode definitions: instruction formats, major opcodes,
// stage-1 payload layout and the decode-side immediate extender.
package instr_encoder_pkg;

    typedef enum logic [2:0] {
        FMT_R = 3'd0,
        FMT_I = 3'd1,
        FMT_S = 3'd2,
        FMT_B = 3'd3,
        FMT_U = 3'd4,
        FMT_J = 3'd5
    } fmt_e;

    localparam logic [6:0] OPC_LOAD     = 7'h03;
    localparam logic [6:0] OPC_MISC_MEM = 7'h0F;
    localparam logic [6:0] OPC_OP_IMM   = 7'h13;
    localparam logic [6:0] OPC_AUIPC    = 7'h17;
    localparam logic [6:0] OPC_STORE    = 7'h23;
    localparam logic [6:0] OPC_OP       = 7'h33;
    localparam logic [6:0] OPC_LUI      = 7'h37;
    localparam logic [6:0] OPC_BRANCH   = 7'h63;
    localparam logic [6:0] OPC_JALR     = 7'h67;
    localparam logic [6:0] OPC_JAL      = 7'h6F;
    localparam logic [6:0] OPC_SYSTEM   = 7'h73;

    localparam logic [15:0] ERR_CNT_MAX = 16'hFFFF;

    // Stage-1 holds the request with its immediate already placed.
    typedef struct packed {
        logic [2:0]  fmt;
        logic [6:0]  opcode;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm_bits;
        logic        err;
    } s1_t;

    function automatic logic fmt_is_valid(input logic [2:0] fmt);
        return fmt <= 3'(FMT_J);
    endfunction

    // Decode-side extender; the encoder is its exact inverse.
    function automatic logic [31:0] imm_extend(input logic [31:0] instr, input logic [2:0] fmt);
        case (fmt_e'(fmt))
            FMT_I:   return {{20{instr[31]}}, instr[31:20]};
            FMT_S:   return {{20{instr[31]}}, instr[31:25], instr[11:7]};
            FMT_B:   return {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            FMT_U:   return {instr[31:12], 12'd0};
            FMT_J:   return {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            default: return 32'd0;
        endcase
    endfunction

endpackage

// File: rtl/instr_encoder_imm_pack.sv
// Immediate placement into the RV32I word plus error flag.
// Define RANGE_CHECK_EN to also flag immediates that do not fit their format.
module imm_pack
    import instr_encoder_pkg::*;
(
    input  logic [31:0] imm,
    input  logic [2:0]  fmt,
    output logic [31:0] bits,
    output logic        err
);

    fmt_e fmt_q;
    assign fmt_q = fmt_e'(fmt);

    always_comb begin
        bits = 32'd0;
        case (fmt_q)
            FMT_I:   bits = {imm[11:0], 20'd0};
            FMT_S:   bits = {imm[11:5], 13'd0, imm[4:0], 7'd0};
            FMT_B:   bits = {imm[12], imm[10:5], 13'd0, imm[4:1], imm[11], 7'd0};
            FMT_U:   bits = {imm[31:12], 12'd0};
            FMT_J:   bits = {imm[20], imm[10:1], imm[11], imm[19:12], 12'd0};
            default: bits = 32'd0;
        endcase
    end

`ifdef RANGE_CHECK_EN
    logic fits12;
    logic fits13;
    logic fits21;

    // A value fits N signed bits when everything above bit N-2 is pure sign.
    assign fits12 = (imm[31:11] == '0) || (imm[31:11] == '1);
    assign fits13 = (imm[31:12] == '0) || (imm[31:12] == '1);
    assign fits21 = (imm[31:20] == '0) || (imm[31:20] == '1);

    always_comb begin
        err = 1'b0;
        case (fmt_q)
            FMT_R:        err = 1'b0;
            FMT_I, FMT_S: err = !fits12;
            FMT_B:        err = !fits13 || imm[0];
            FMT_J:        err = !fits21 || imm[0];
            FMT_U:        err = (imm[11:0] != 12'd0);
            default:      err = 1'b1;
        endcase
    end
`else
    assign err = !fmt_is_valid(fmt);
`endif

endmodule

// File: rtl/instr_encoder.sv
// Two-stage RV32I instruction encoder with valid/ready handshake and a
// saturating error counter. Range checking is enabled by RANGE_CHECK_EN.
module instr_encoder
    import instr_encoder_pkg::*;
(
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  fmt,
    input  logic [6:0]  opcode,
    input  logic [2:0]  funct3,
    input  logic [6:0]  funct7,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [31:0] imm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic        out_err,
    output logic [15:0] err_cnt
);

    s1_t         s1;
    s1_t         s1_next;
    logic        s1_valid;
    logic        s2_adv;
    logic [31:0] imm_bits;
    logic        imm_err;
    logic [31:0] word;

    imm_pack u_imm_pack (
        .imm  (imm),
        .fmt  (fmt),
        .bits (imm_bits),
        .err  (imm_err)
    );

    assign s2_adv   = !out_valid || out_ready;
    assign in_ready = !s1_valid || s2_adv;

    always_comb begin
        s1_next          = '0;
        s1_next.fmt      = fmt;
        s1_next.opcode   = opcode;
        s1_next.funct3   = funct3;
        s1_next.funct7   = funct7;
        s1_next.rd       = rd;
        s1_next.rs1      = rs1;
        s1_next.rs2      = rs2;
        s1_next.imm_bits = imm_bits;
        s1_next.err      = imm_err;
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            s1_valid <= 1'b0;
            s1       <= '0;
        end else if (in_ready) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1 <= s1_next;
            end
        end
    end

    // Register fields are merged around the already-placed immediate bits.
    always_comb begin
        word = 32'd0;
        case (fmt_e'(s1.fmt))
            FMT_R:        word = {s1.funct7, s1.rs2, s1.rs1, s1.funct3, s1.rd, s1.opcode};
            FMT_I:        word = s1.imm_bits | {12'd0, s1.rs1, s1.funct3, s1.rd, s1.opcode};
            FMT_S, FMT_B: word = s1.imm_bits | {7'd0, s1.rs2, s1.rs1, s1.funct3, 5'd0, s1.opcode};
            FMT_U, FMT_J: word = s1.imm_bits | {20'd0, s1.rd, s1.opcode};
            default:      word = 32'd0;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            out_valid <= 1'b0;
            out_instr <= 32'd0;
            out_err   <= 1'b0;
        end else if (s2_adv) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_instr <= word;
                out_err   <= s1.err;
            end
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            err_cnt <= 16'd0;
        end else if (out_valid && out_ready && out_err && (err_cnt != ERR_CNT_MAX)) begin
            err_cnt <= err_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder: expected words are queued at acceptance
// and compared in order as the encoder hands them downstream.
module tb_instr_encoder;

    logic        CLK = 1'b0;
    logic        RESET_N;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  fmt = 3'd0;
    logic [6:0]  opcode = 7'd0;
    logic [2:0]  funct3 = 3'd0;
    logic [6:0]  funct7 = 7'd0;
    logic [4:0]  rd = 5'd0;
    logic [4:0]  rs1 = 5'd0;
    logic [4:0]  rs2 = 5'd0;
    logic [31:0] imm = 32'd0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_instr;
    logic        out_err;
    logic [15:0] err_cnt;

`ifdef RANGE_CHECK_EN
    localparam bit RC = 1'b1;
`else
    localparam bit RC = 1'b0;
`endif

    int          tests_run = 0;
    int          tests_failed = 0;
    int          n_out = 0;
    logic [32:0] sb[$];
    logic [15:0] exp_cnt = 16'd0;
    logic        prev_stall = 1'b0;
    logic [31:0] prev_instr = 32'd0;
    logic        prev_err = 1'b0;

    instr_encoder dut (
        .CLK       (CLK),
        .RESET_N   (RESET_N),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .fmt       (fmt),
        .opcode    (opcode),
        .funct3    (funct3),
        .funct7    (funct7),
        .rd        (rd),
        .rs1       (rs1),
        .rs2       (rs2),
        .imm       (imm),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_instr (out_instr),
        .out_err   (out_err),
        .err_cnt   (err_cnt)
    );

    always #5 CLK = ~CLK;

    function automatic logic [32:0] model(input logic [2:0] f, input logic [6:0] op,
                                          input logic [2:0] f3, input logic [6:0] f7,
                                          input logic [4:0] d, input logic [4:0] a,
                                          input logic [4:0] b, input logic [31:0] im);
        logic [31:0] w;
        logic        e;
        logic        rng;
        w = 32'd0;
        e = 1'b0;
        rng = 1'b0;
        case (f)
            3'd0: w = {f7, b, a, f3, d, op};
            3'd1: begin
                w = {im[11:0], a, f3, d, op};
                rng = ($signed(im) > 2047) || ($signed(im) < -2048);
            end
            3'd2: begin
                w = {im[11:5], b, a, f3, im[4:0], op};
                rng = ($signed(im) > 2047) || ($signed(im) < -2048);
            end
            3'd3: begin
                w = {im[12], im[10:5], b, a, f3, im[4:1], im[11], op};
                rng = ($signed(im) > 4095) || ($signed(im) < -4096) || im[0];
            end
            3'd4: begin
                w = {im[31:12], d, op};
                rng = (im[11:0] != 12'd0);
            end
            3'd5: begin
                w = {im[20], im[10:1], im[11], im[19:12], d, op};
                rng = ($signed(im) > 1048575) || ($signed(im) < -1048576) || im[0];
            end
            default: begin
                w = 32'd0;
                e = 1'b1;
            end
        endcase
        e = e | (RC & rng);
        return {e, w};
    endfunction

    function automatic logic [31:0] ext_j(input logic [31:0] w);
        return {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
    endfunction

    // Monitor: in-order scoreboard, stall stability and error-counter tracking.
    always @(negedge CLK) begin
        logic [32:0] exp;
        if (RESET_N !== 1'b1) begin
            exp_cnt    = 16'd0;
            prev_stall = 1'b0;
        end else begin
            tests_run++;
            if (err_cnt !== exp_cnt) begin
                tests_failed++;
                $display("FAIL err_cnt: got %h want %h", err_cnt, exp_cnt);
            end
            if (prev_stall) begin
                tests_run++;
                if ({out_valid, out_err, out_instr} !== {1'b1, prev_err, prev_instr}) begin
                    tests_failed++;
                    $display("FAIL stall_hold: got v=%b e=%b %h want v=1 e=%b %h",
                             out_valid, out_err, out_instr, prev_err, prev_instr);
                end
            end
            if (out_valid && out_ready) begin
                tests_run++;
                if (sb.size() == 0) begin
                    tests_failed++;
                    $display("FAIL unexpected_word: got e=%b %h want no word", out_err, out_instr);
                end else begin
                    exp = sb.pop_front();
                    n_out++;
                    if ({out_err, out_instr} !== exp) begin
                        tests_failed++;
                        $display("FAIL scoreboard: got e=%b %h want e=%b %h",
                                 out_err, out_instr, exp[32], exp[31:0]);
                    end
                    if (exp[32] && exp_cnt != 16'hFFFF) exp_cnt++;
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_instr = out_instr;
            prev_err   = out_err;
        end
    end

    task automatic put(input logic [2:0] f, input logic [6:0] op, input logic [2:0] f3,
                       input logic [6:0] f7, input logic [4:0] d, input logic [4:0] a,
                       input logic [4:0] b, input logic [31:0] im, input logic [32:0] exp);
        logic got;
        fmt = f; opcode = op; funct3 = f3; funct7 = f7;
        rd = d; rs1 = a; rs2 = b; imm = im;
        in_valid = 1'b1;
        got = 1'b0;
        for (int t = 0; t < 64 && !got; t++) begin
            @(negedge CLK);
            got = in_ready;
            @(posedge CLK);
            #1;
        end
        tests_run++;
        if (got) sb.push_back(exp);
        else begin
            tests_failed++;
            $display("FAIL put_timeout: got in_ready=0 want accept within 64 cycles");
        end
    endtask

    task automatic drain();
        for (int t = 0; t < 200 && sb.size() != 0; t++) begin
            @(posedge CLK);
            #1;
        end
        @(posedge CLK);
        #1;
        tests_run++;
        if (sb.size() != 0) begin
            tests_failed++;
            $display("FAIL drain_timeout: got %0d pending want 0", sb.size());
        end
    endtask

    task automatic test_reset();
        RESET_N = 1'b0;
        #12;
        tests_run++;
        if ({out_valid, out_err, out_instr, err_cnt} !== 50'd0) begin
            tests_failed++;
            $display("FAIL reset_state: got v=%b e=%b %h cnt=%h want all zero",
                     out_valid, out_err, out_instr, err_cnt);
        end
        @(negedge CLK);
        RESET_N = 1'b1;
        @(posedge CLK);
        #1;
        tests_run++;
        if (in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
    endtask

    task automatic test_latency();
        fmt = 3'd1; opcode = 7'h13; funct3 = 3'd0; funct7 = 7'd0;
        rd = 5'd1; rs1 = 5'd0; rs2 = 5'd0; imm = 32'd5;
        in_valid = 1'b1;
        tests_run++;
        if (in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL lat_accept: got in_ready=%b want 1", in_ready);
        end
        @(posedge CLK);
        #1;
        in_valid = 1'b0;
        sb.push_back({1'b0, 32'h00500093});
        tests_run++;
        if (out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL lat_early: got out_valid=%b want 0", out_valid);
        end
        @(posedge CLK);
        #1;
        tests_run++;
        if ({out_valid, out_err, out_instr} !== {1'b1, 1'b0, 32'h00500093}) begin
            tests_failed++;
            $display("FAIL lat_addi: got v=%b e=%b %h want v=1 e=0 00500093",
                     out_valid, out_err, out_instr);
        end
        drain();
    endtask

    task automatic test_errors();
        put(3'd1, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd2048, {RC, 32'h80000093});
        in_valid = 1'b0;
        drain();
        tests_run++;
        if (err_cnt !== (RC ? 16'd1 : 16'd0)) begin
            tests_failed++;
            $display("FAIL err_range_cnt: got %h want %h", err_cnt, (RC ? 16'd1 : 16'd0));
        end
        put(3'd7, 7'h13, 3'd1, 7'h7F, 5'd3, 5'd4, 5'd5, 32'h0000_0123, {1'b1, 32'd0});
        in_valid = 1'b0;
        drain();
        tests_run++;
        if (err_cnt !== (RC ? 16'd2 : 16'd1)) begin
            tests_failed++;
            $display("FAIL err_fmt_cnt: got %h want %h", err_cnt, (RC ? 16'd2 : 16'd1));
        end
    endtask

    task automatic test_formats();
        put(3'd2, 7'h23, 3'd2, 7'd0, 5'd0, 5'd1, 5'd2, 32'd8, {1'b0, 32'h0020A423});
        put(3'd3, 7'h63, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'hFFFF_FFFC, {1'b0, 32'hFE000EE3});
        put(3'd0, 7'h33, 3'd0, 7'h20, 5'd3, 5'd4, 5'd5,
            32'hDEAD_BEEF, model(3'd0, 7'h33, 3'd0, 7'h20, 5'd3, 5'd4, 5'd5, 32'hDEAD_BEEF));
        put(3'd4, 7'h37, 3'd0, 7'd0, 5'd7, 5'd0, 5'd0,
            32'h1234_5000, model(3'd4, 7'h37, 3'd0, 7'd0, 5'd7, 5'd0, 5'd0, 32'h1234_5000));
        put(3'd6, 7'h13, 3'd0, 7'd0, 5'd1, 5'd1, 5'd1, 32'd1, {1'b1, 32'd0});
        in_valid = 1'b0;
        drain();
        put(3'd5, 7'h6F, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'h0000_0800, {1'b0, 32'h001000EF});
        in_valid = 1'b0;
        for (int t = 0; t < 10 && !out_valid; t++) @(negedge CLK);
        tests_run++;
        if (ext_j(out_instr) !== 32'h0000_0800 || out_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL j_reextend: got v=%b %h want v=1 00000800", out_valid, ext_j(out_instr));
        end
        drain();
    endtask

    task automatic test_back_to_back();
        int start;
        start = n_out;
        out_ready = 1'b1;
        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    put(3'd1, 7'h13, 3'(i), 7'd0, 5'(i + 1), 5'(i), 5'd0, 32'(i * 37 - 100),
                        model(3'd1, 7'h13, 3'(i), 7'd0, 5'(i + 1), 5'(i), 5'd0, 32'(i * 37 - 100)));
                end
                in_valid = 1'b0;
            end
            begin
                for (int c = 1; c <= 12; c++) begin
                    @(posedge CLK);
                    #1;
                    out_ready = !(c >= 3 && c <= 6);
                    if (c == 5) begin
                        @(negedge CLK);
                        tests_run++;
                        if (in_ready !== 1'b0) begin
                            tests_failed++;
                            $display("FAIL b2b_full_ready: got %b want 0", in_ready);
                        end
                    end
                end
                out_ready = 1'b1;
            end
        join
        drain();
        tests_run++;
        if (n_out - start != 8) begin
            tests_failed++;
            $display("FAIL b2b_count: got %0d want 8", n_out - start);
        end
    endtask

    task automatic test_random();
        logic done;
        done = 1'b0;
        fork
            begin
                for (int i = 0; i < 40; i++) begin
                    logic [2:0]  f;
                    logic [31:0] r, im;
                    logic [6:0]  op, f7;
                    logic [4:0]  d, a, b;
                    logic [2:0]  f3;
                    f = 3'($urandom_range(0, 7));
                    r = $urandom;
                    case ($urandom_range(0, 3))
                        0: im = r;
                        1: im = 32'($urandom_range(0, 8191)) - 32'd4096;
                        2: im = {r[31:12], 12'd0};
                        default: im = (32'($urandom_range(0, 2097151)) - 32'd1048576) & 32'hFFFF_FFFE;
                    endcase
                    op = 7'($urandom); f7 = 7'($urandom); f3 = 3'($urandom);
                    d = 5'($urandom); a = 5'($urandom); b = 5'($urandom);
                    put(f, op, f3, f7, d, a, b, im, model(f, op, f3, f7, d, a, b, im));
                    if ($urandom_range(0, 3) == 0) begin
                        in_valid = 1'b0;
                        @(posedge CLK);
                        #1;
                    end
                end
                in_valid = 1'b0;
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge CLK);
                    #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
                out_ready = 1'b1;
            end
        join
        drain();
    endtask

    task automatic test_reset_midflight();
        int start;
        int seen;
        out_ready = 1'b1;
        put(3'd6, 7'h13, 3'd0, 7'd0, 5'd1, 5'd1, 5'd1, 32'd0, {1'b1, 32'd0});
        put(3'd1, 7'h13, 3'd0, 7'd0, 5'd2, 5'd3, 5'd0, 32'd9,
            model(3'd1, 7'h13, 3'd0, 7'd0, 5'd2, 5'd3, 5'd0, 32'd9));
        in_valid = 1'b0;
        #1;
        RESET_N = 1'b0;
        #1;
        sb.delete();
        tests_run++;
        if ({out_valid, out_err, out_instr, err_cnt} !== 50'd0) begin
            tests_failed++;
            $display("FAIL midreset_clear: got v=%b e=%b %h cnt=%h want all zero",
                     out_valid, out_err, out_instr, err_cnt);
        end
        @(posedge CLK);
        @(negedge CLK);
        RESET_N = 1'b1;
        start = n_out;
        seen = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge CLK);
            if (out_valid) seen++;
        end
        tests_run++;
        if (seen != 0 || n_out != start) begin
            tests_failed++;
            $display("FAIL midreset_stale: got %0d valid cycles want 0", seen);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_latency();
        test_errors();
        test_formats();
        test_back_to_back();
        test_random();
        test_reset_midflight();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 SHALL have no parameters; all widths are fixed by RV32I.
REQ-002 SHALL have ports, in order: CLK in 1 system clock; RESET_N in 1 asynchronous active-low reset.
REQ-003 SHALL have port in_valid in 1: request present.
REQ-004 SHALL have port in_ready out 1: request accepted when in_valid and in_ready are both high on a CLK edge.
REQ-005 SHALL have port fmt in 3: 0=R, 1=I, 2=S, 3=B, 4=U, 5=J, 6..7 invalid.
REQ-006 SHALL have ports opcode in 7, funct3 in 3, funct7 in 7, rd in 5, rs1 in 5 and rs2 in 5, each an instruction field.
REQ-007 SHALL have port imm in 32: signed byte-offset or value (U: the full upper value, bits[11:0] expected zero).
REQ-008 SHALL have ports out_valid out 1, out_ready in 1 and out_instr out 32 (encoded word).
REQ-009 SHALL have port out_err out 1: the word is flagged bad.
REQ-010 SHALL have port err_cnt out 16: saturating count of flagged words.

Function
REQ-011 SHALL be the inverse of the immediate extender: the bit placements for I/S/B/J/U SHALL exactly match the RV32I decode, so that extend(encode(x)) returns imm for every in-range imm.
REQ-012 SHALL pack R as funct7|rs2|rs1|funct3|rd|opcode; I as imm[11:0]|rs1|funct3|rd|opcode.
REQ-013 SHALL pack S as imm[11:5]|rs2|rs1|funct3|imm[4:0]|opcode; B as imm[12]|imm[10:5]|rs2|rs1|funct3|imm[4:1]|imm[11]|opcode.
REQ-014 SHALL pack U as imm[31:12]|rd|opcode; J as imm[20]|imm[10:1]|imm[11]|imm[19:12]|rd|opcode.
REQ-015 SHALL be a 2-stage pipeline: stage 1 registers the request and its error flag; stage 2 registers the assembled word; latency from acceptance to out_valid SHALL be exactly 2 cycles with no stall.
REQ-016 SHALL give each stage a valid bit and advance a stage when it is empty or the next stage advances; in_ready = !s1_valid || s2_advance; s2 advances when !out_valid || out_ready.
REQ-017 SHALL hold out_instr/out_err stable while out_valid && !out_ready; no word lost or duplicated.
REQ-018 SHALL sustain throughput of 1 word/cycle when out_ready stays high.
REQ-019 SHALL, for invalid fmt, produce out_instr=0 and out_err=1.
REQ-020 SHALL emit flagged words (not drop them) with fields truncated per REQ-012..014.
REQ-021 SHALL increment err_cnt on the cycle an out_err=1 word is accepted downstream (out_valid && out_ready); it SHALL saturate at 0xFFFF.

Reset
REQ-022 SHALL, while RESET_N is low, asynchronously clear all valid bits, out_valid=0, out_instr=0, out_err=0 and err_cnt=0; in_ready SHALL be 1 from the first edge after release.
REQ-023 SHALL discard words in flight when reset asserts mid-operation; none SHALL reappear after release.

Configuration
REQ-024 SHALL, with RANGE_CHECK_EN defined, set the error flag when: I/S imm not 12-bit signed; B imm not 13-bit signed or imm[0]=1; J imm not 21-bit signed or imm[0]=1; U imm[11:0]!=0.
REQ-025 SHALL, without RANGE_CHECK_EN, flag only invalid fmt, with no range logic present.

Structure
REQ-026 SHALL place the fmt enum (FMT_R..FMT_J) and the RV32I opcode constants in the shared package, also used by the decode side.
REQ-027 SHALL put the immediate placement and range check in one combinational sub-module, imm_pack (imm, fmt -> bits, err); the pipeline and counter SHALL live in instr_encoder.

Verification
REQ-028 SHALL cover: I, opcode 0x13, rd=1, rs1=0, funct3=0, imm=5 -> out_instr 0x00500093, err=0, 2 cycles after acceptance.
REQ-029 SHALL cover: S, opcode 0x23, funct3=2, rs1=1, rs2=2, imm=8 -> 0x0020A423; B, opcode 0x63, x0/x0, imm=-4 -> 0xFE000EE3.
REQ-030 SHALL cover: J, opcode 0x6F, rd=1, imm=0x800 -> 0x001000EF; re-extending with the J type SHALL yield 0x00000800.
REQ-031 SHALL cover: RANGE_CHECK_EN set, I, imm=2048 -> err=1, err_cnt=1; fmt=7 -> out_instr=0, err=1, err_cnt=2.
REQ-032 SHALL cover: 8 back-to-back requests with out_ready low for cycles 3..6 -> all 8 words in order, out_instr stable while stalled, in_ready low once both stages are full.
REQ-033 SHALL cover: RESET_N pulsed low with 2 words in flight -> out_valid=0 and err_cnt=0 immediately; no stale word after release.
